// File: rtl/core_pkg.sv
// Shared core definitions: default integer register file geometry, register
// address type and the hardwired-zero register index.
package core_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage : core_pkg

// File: rtl/regfile_rdport.sv
// One combinational read port of the integer register file: x0 squash,
// optional same-cycle writeback forwarding, then array and busy lookup.
module regfile_rdport
  import core_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic [AW-1:0]         addr_i,
  input  logic [NREGS*XLEN-1:0] regs_flat_i,
  input  logic [NREGS-1:0]      busy_flat_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         wa_i,
  input  logic [XLEN-1:0]       wd_i,
  output logic [XLEN-1:0]       data_o,
  output logic                  busy_o
);

  logic fwd_hit;

  // Forwarded data has just been produced, so it can never be busy.
  assign fwd_hit = (BYPASS != 0) && we_i && (wa_i == addr_i);

  always_comb begin
    data_o = '0;
    busy_o = 1'b0;
    if (addr_i != AW'(REG_ZERO)) begin
      if (fwd_hit) begin
        data_o = wd_i;
      end else begin
        data_o = regs_flat_i[addr_i*XLEN +: XLEN];
        busy_o = busy_flat_i[addr_i];
      end
    end
  end

endmodule : regfile_rdport

// File: rtl/regfile_sb.sv
// Integer register file with N read ports, one write port and a per-register
// busy scoreboard set at issue and cleared at writeback. x0 is constant zero.
module regfile_sb
  import core_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [XLEN-1:0]       wd,
  input  logic                  mark_en,
  input  logic [AW-1:0]         mark_addr,
  output logic                  busy_any
);

  // Only registers 1..NREGS-1 are stored; x0 is spliced in as a constant.
  logic [NREGS-1:1][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:1]           busy_q, busy_d;

  logic [NREGS*XLEN-1:0]      regs_flat;
  logic [NREGS-1:0]           busy_flat;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (we && (wa == AW'(r))) begin
        regs_d[r] = wd;
        busy_d[r] = 1'b0;
      end
      // A new producer marked in the writeback cycle takes precedence.
      if (mark_en && (mark_addr == AW'(r))) begin
        busy_d[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign regs_flat = {regs_q, {XLEN{1'b0}}};
  assign busy_flat = {busy_q, 1'b0};
  assign busy_any  = |busy_q;

  for (genvar p = 0; p < NREAD; p++) begin : g_rdport
    regfile_rdport #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .BYPASS (BYPASS)
    ) u_rdport (
      .addr_i      (rd_addr[p*AW +: AW]),
      .regs_flat_i (regs_flat),
      .busy_flat_i (busy_flat),
      .we_i        (we),
      .wa_i        (wa),
      .wd_i        (wd),
      .data_o      (rd_data[p*XLEN +: XLEN]),
      .busy_o      (rd_busy[p])
    );
  end

endmodule : regfile_sb
